// File: rtl/timesync_multi_if.sv
// Command-decoder bundle: cmd/arg stream into timesync_multi, param stream and completion back out.
// The decoder side is the master; timesync_multi is the slave.
interface timesync_multi_if #(
    parameter int CMD_BITS = 8
);
    logic [31:0]         arg_data;
    logic                arg_advance;
    logic [CMD_BITS-1:0] cmd;
    logic                cmd_ready;
    logic                cmd_done;
    logic [31:0]         param_data;
    logic                param_write;

    modport master (
        output arg_data, cmd, cmd_ready,
        input  arg_advance, cmd_done, param_data, param_write
    );

    modport slave (
        input  arg_data, cmd, cmd_ready,
        output arg_advance, cmd_done, param_data, param_write
    );
endinterface

// File: rtl/timesync_multi.sv
// System command handler with NLATCH timestamp latches; responses are registered (first word one cycle
// after accept), arg_advance is combinational, and no backpressure exists: words stream one per cycle.
module timesync_multi #(
    parameter int CMD_BITS         = 8,
    parameter int TIME_BITS        = 64,
    parameter int NLATCH           = 2,
    parameter int SYNC_STAGES      = 2,
    parameter int VERSION          = 2,
    parameter int CMD_GET_VERSION  = 0,
    parameter int CMD_SYNC_TIME    = 1,
    parameter int CMD_GET_TIME     = 2,
    parameter int CMD_GET_LATCH    = 3,
    parameter int CMD_CONFIG_LATCH = 4,
    parameter int RSP_GET_VERSION  = 0,
    parameter int RSP_GET_TIME     = 1,
    parameter int RSP_GET_LATCH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    timesync_multi_if.slave      bus,
    input  logic [TIME_BITS-1:0] time_in,
    output logic [TIME_BITS-1:0] time_out,
    output logic                 time_out_en,
    input  logic [NLATCH-1:0]    latch_in
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_VER0      = 4'd1;
    localparam logic [3:0] S_VER1      = 4'd2;
    localparam logic [3:0] S_VER_END   = 4'd3;
    localparam logic [3:0] S_SYNC_LO   = 4'd4;
    localparam logic [3:0] S_SYNC_HI   = 4'd5;
    localparam logic [3:0] S_TIME_HI   = 4'd6;
    localparam logic [3:0] S_TIME_END  = 4'd7;
    localparam logic [3:0] S_LAT_FLAGS = 4'd8;
    localparam logic [3:0] S_LAT_LO    = 4'd9;
    localparam logic [3:0] S_LAT_HI    = 4'd10;
    localparam logic [3:0] S_LAT_END   = 4'd11;
    localparam logic [3:0] S_DONE_ONLY = 4'd12;

    localparam int MW = $clog2(SYNC_STAGES + 2);

    logic [3:0]           state_q, state_d;
    logic [31:0]          param_data_q, param_data_d;
    logic                 param_write_q, param_write_d;
    logic                 cmd_done_q, cmd_done_d;
    logic [TIME_BITS-1:0] time_out_q, time_out_d;
    logic                 time_out_en_q, time_out_en_d;
    logic [31:0]          ch_q, ch_d, lo_q, lo_d;
    logic [TIME_BITS-1:0] snap_q, snap_d;
    logic [NLATCH-1:0]    edge_mask_q, edge_mask_d;

    logic [SYNC_STAGES-1:0][NLATCH-1:0] sync_q;
    logic [NLATCH-1:0]    prev_q, valid_q, overrun_q;
    logic [TIME_BITS-1:0] latched_q [NLATCH];
    logic [MW-1:0]        mask_cnt_q;

    logic [NLATCH-1:0]    sync_out, evt, clr;
    logic                 adv;
    logic [31:0]          sel_ch;
    logic                 sel_hit, sel_valid, sel_over;
    logic [TIME_BITS-1:0] sel_time;
    logic [63:0]          snap_ext, arg64;

    assign snap_ext = 64'(snap_q);
    assign arg64    = {bus.arg_data, lo_q};

    // Channel lookup: GET_LATCH indexes with the live argument, SYNC_TIME with the stored one.
    always_comb begin
        sel_ch    = (state_q == S_IDLE) ? bus.arg_data : ch_q;
        sel_hit   = 1'b0;
        sel_valid = 1'b0;
        sel_over  = 1'b0;
        sel_time  = '0;
        for (int c = 0; c < NLATCH; c++) begin
            if (sel_ch == 32'(c)) begin
                sel_hit   = 1'b1;
                sel_valid = valid_q[c];
                sel_over  = overrun_q[c];
                sel_time  = latched_q[c];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        param_data_d  = '0;
        param_write_d = 1'b0;
        cmd_done_d    = 1'b0;
        time_out_d    = time_out_q;
        time_out_en_d = 1'b0;
        ch_d          = ch_q;
        lo_d          = lo_q;
        snap_d        = snap_q;
        edge_mask_d   = edge_mask_q;
        clr           = '0;
        adv           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_ready) begin
                    if (bus.cmd == CMD_BITS'(CMD_GET_VERSION)) begin
                        param_data_d  = 32'(VERSION);
                        param_write_d = 1'b1;
                        state_d       = S_VER0;
                    end else if (bus.cmd == CMD_BITS'(CMD_GET_TIME)) begin
                        snap_d        = time_in;
                        param_data_d  = time_in[31:0];
                        param_write_d = 1'b1;
                        state_d       = S_TIME_HI;
                    end else if (bus.cmd == CMD_BITS'(CMD_SYNC_TIME)) begin
                        adv     = 1'b1;
                        ch_d    = bus.arg_data;
                        state_d = S_SYNC_LO;
                    end else if (bus.cmd == CMD_BITS'(CMD_GET_LATCH)) begin
                        adv           = 1'b1;
                        snap_d        = sel_time;
                        param_data_d  = {30'b0, sel_over, sel_valid};
                        param_write_d = 1'b1;
                        for (int c = 0; c < NLATCH; c++) clr[c] = (sel_ch == 32'(c));
                        state_d       = S_LAT_FLAGS;
                    end else if (bus.cmd == CMD_BITS'(CMD_CONFIG_LATCH)) begin
                        adv         = 1'b1;
                        edge_mask_d = bus.arg_data[NLATCH-1:0];
                        clr         = '1;
                        cmd_done_d  = 1'b1;
                        state_d     = S_DONE_ONLY;
                    end else begin
                        cmd_done_d = 1'b1;
                        state_d    = S_DONE_ONLY;
                    end
                end
            end
            S_VER0: begin
                param_data_d  = {16'(NLATCH), 16'(TIME_BITS)};
                param_write_d = 1'b1;
                state_d       = S_VER1;
            end
            S_VER1: begin
                param_data_d = 32'(RSP_GET_VERSION);
                cmd_done_d   = 1'b1;
                state_d      = S_VER_END;
            end
            S_TIME_HI: begin
                param_data_d  = snap_ext[63:32];
                param_write_d = 1'b1;
                state_d       = S_TIME_END;
            end
            S_TIME_END: begin
                param_data_d = 32'(RSP_GET_TIME);
                cmd_done_d   = 1'b1;
                state_d      = S_DONE_ONLY;
            end
            S_SYNC_LO: begin
                adv     = 1'b1;
                lo_d    = bus.arg_data;
                state_d = S_SYNC_HI;
            end
            S_SYNC_HI: begin
                adv = 1'b1;
                // The +SYNC_STAGES+2 term compensates for the synchroniser and capture delay.
                if (sel_hit && sel_valid) begin
                    time_out_d    = time_in - sel_time + TIME_BITS'(arg64) + TIME_BITS'(SYNC_STAGES + 2);
                    time_out_en_d = 1'b1;
                    for (int c = 0; c < NLATCH; c++) clr[c] = (sel_ch == 32'(c));
                end
                cmd_done_d = 1'b1;
                state_d    = S_DONE_ONLY;
            end
            S_LAT_FLAGS: begin
                param_data_d  = snap_ext[31:0];
                param_write_d = 1'b1;
                state_d       = S_LAT_LO;
            end
            S_LAT_LO: begin
                param_data_d  = snap_ext[63:32];
                param_write_d = 1'b1;
                state_d       = S_LAT_HI;
            end
            S_LAT_HI: begin
                param_data_d = 32'(RSP_GET_LATCH);
                cmd_done_d   = 1'b1;
                state_d      = S_LAT_END;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            param_data_q  <= '0;
            param_write_q <= 1'b0;
            cmd_done_q    <= 1'b0;
            time_out_q    <= '0;
            time_out_en_q <= 1'b0;
            ch_q          <= '0;
            lo_q          <= '0;
            snap_q        <= '0;
            edge_mask_q   <= '0;
        end else begin
            state_q       <= state_d;
            param_data_q  <= param_data_d;
            param_write_q <= param_write_d;
            cmd_done_q    <= cmd_done_d;
            time_out_q    <= time_out_d;
            time_out_en_q <= time_out_en_d;
            ch_q          <= ch_d;
            lo_q          <= lo_d;
            snap_q        <= snap_d;
            edge_mask_q   <= edge_mask_d;
        end
    end

    // Edges are ignored while the synchroniser refills after reset.
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        evt      = '0;
        if (mask_cnt_q == '0)
            evt = (edge_mask_q & sync_out & ~prev_q) | (~edge_mask_q & ~sync_out & prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= '0;
            valid_q    <= '0;
            overrun_q  <= '0;
            mask_cnt_q <= MW'(SYNC_STAGES + 1);
            for (int c = 0; c < NLATCH; c++) latched_q[c] <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], latch_in};
            prev_q <= sync_out;
            if (mask_cnt_q != '0) mask_cnt_q <= mask_cnt_q - MW'(1);
            for (int c = 0; c < NLATCH; c++) begin
                if (evt[c]) begin
                    latched_q[c] <= time_in;
                    valid_q[c]   <= 1'b1;
                    overrun_q[c] <= valid_q[c] & ~clr[c];
                end else if (clr[c]) begin
                    valid_q[c]   <= 1'b0;
                    overrun_q[c] <= 1'b0;
                end
            end
        end
    end

    assign bus.arg_advance = adv & ~rst;
    assign bus.cmd_done    = cmd_done_q;
    assign bus.param_data  = param_data_q;
    assign bus.param_write = param_write_q;
    assign time_out        = time_out_q;
    assign time_out_en     = time_out_en_q;
endmodule

// File: tb/tb_timesync_multi.sv
// Randomised bench for timesync_multi against a transaction-level model of latches and commands.
module tb_timesync_multi;
    localparam int S = 2;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   time_in;
    logic [63:0]   time_out;
    logic          time_out_en;
    logic [N-1:0]  latch_in;

    timesync_multi_if #(.CMD_BITS(8)) bus();

    timesync_multi #(
        .CMD_BITS(8), .TIME_BITS(64), .NLATCH(N), .SYNC_STAGES(S), .VERSION(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .time_in(time_in), .time_out(time_out), .time_out_en(time_out_en),
        .latch_in(latch_in)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-channel flags, captured times and edge polarity.
    logic        m_valid [N];
    logic        m_over  [N];
    logic [63:0] m_lat   [N];
    logic [N-1:0] m_mask;
    logic [31:0] exp_w [$];

    function automatic logic [63:0] rnd64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    task automatic m_reset();
        m_mask = '0;
        for (int c = 0; c < N; c++) begin
            m_valid[c] = 1'b0; m_over[c] = 1'b0; m_lat[c] = '0;
        end
    endtask

    // Toggle channels with time_in held; an edge counts when the new level matches the polarity bit.
    task automatic latch_toggle(input logic [N-1:0] which, input logic [63:0] t);
        time_in = t;
        for (int c = 0; c < N; c++) begin
            if (which[c]) begin
                latch_in[c] = ~latch_in[c];
                if (latch_in[c] == m_mask[c]) begin
                    m_over[c] = m_valid[c]; m_valid[c] = 1'b1; m_lat[c] = t;
                end
            end
        end
        repeat (S + 3) @(negedge clk);
    endtask

    // Issues one command from the current negedge and observes until cmd_done (bounded).
    task automatic run_cmd(input string tag, input logic [7:0] c,
                           input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                           input int exp_adv, input int exp_done_k, input logic chk_code,
                           input logic [31:0] exp_code, input int exp_en, input logic [63:0] exp_tout);
        logic [31:0] args [3];
        logic [31:0] got_w [$];
        int nadv = 0, nen = 0, done_k = -1, ai = 0, en_k = -1;
        logic [31:0] code = '0;
        logic [63:0] tout = '0;
        args[0] = a0; args[1] = a1; args[2] = a2;
        bus.cmd = c;
        bus.cmd_ready = 1'b1;
        for (int k = 0; k < 12 && done_k < 0; k++) begin
            bus.arg_data = (ai < 3) ? args[ai] : 32'($urandom);
            #1;
            if (bus.arg_advance) begin nadv++; ai++; end
            if (bus.param_write) got_w.push_back(bus.param_data);
            if (time_out_en) begin nen++; tout = time_out; en_k = k; end
            if (bus.cmd_done) begin done_k = k; code = bus.param_data; end
            @(negedge clk);
            bus.cmd_ready = 1'b0;
            bus.cmd = 8'($urandom);
        end
        check($sformatf("%s/done_cycle", tag), 64'(done_k), 64'(exp_done_k));
        check($sformatf("%s/arg_advance", tag), 64'(nadv), 64'(exp_adv));
        check($sformatf("%s/nwords", tag), 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++)
            check($sformatf("%s/word%0d", tag, i), (i < got_w.size()) ? 64'(got_w[i]) : '1, 64'(exp_w[i]));
        if (chk_code) check($sformatf("%s/code", tag), 64'(code), 64'(exp_code));
        check($sformatf("%s/time_out_en", tag), 64'(nen), 64'(exp_en));
        if (nen > 0) begin
            check($sformatf("%s/time_out", tag), tout, exp_tout);
            check($sformatf("%s/en_with_done", tag), 64'(en_k), 64'(done_k));
        end
    endtask

    task automatic do_version();
        exp_w.delete(); exp_w.push_back(32'd2); exp_w.push_back(32'h0002_0040);
        run_cmd("version", 8'd0, 0, 0, 0, 0, 3, 1'b1, 32'd0, 0, '0);
    endtask

    task automatic do_time(input logic [63:0] t);
        time_in = t;
        exp_w.delete(); exp_w.push_back(t[31:0]); exp_w.push_back(t[63:32]);
        run_cmd("get_time", 8'd2, 0, 0, 0, 0, 3, 1'b1, 32'd1, 0, '0);
    endtask

    task automatic do_latch(input int ch);
        logic [31:0] fl = '0;
        logic [63:0] tm = '0;
        if (ch < N) begin
            fl = {30'b0, m_over[ch], m_valid[ch]}; tm = m_lat[ch];
            m_valid[ch] = 1'b0; m_over[ch] = 1'b0;
        end
        exp_w.delete(); exp_w.push_back(fl); exp_w.push_back(tm[31:0]); exp_w.push_back(tm[63:32]);
        run_cmd($sformatf("get_latch%0d", ch), 8'd3, 32'(ch), 0, 0, 1, 4, 1'b1, 32'd2, 0, '0);
    endtask

    task automatic do_sync(input int ch, input logic [63:0] v, input logic [63:0] t);
        int en = 0;
        logic [63:0] tout = '0;
        time_in = t;
        if (ch < N && m_valid[ch]) begin
            en = 1; tout = t - m_lat[ch] + v + 64'(S + 2);
            m_valid[ch] = 1'b0; m_over[ch] = 1'b0;
        end
        exp_w.delete();
        run_cmd($sformatf("sync%0d", ch), 8'd1, 32'(ch), v[31:0], v[63:32], 3, 3, 1'b0, '0, en, tout);
    endtask

    task automatic do_config(input logic [31:0] mask);
        m_mask = mask[N-1:0];
        for (int c = 0; c < N; c++) begin m_valid[c] = 1'b0; m_over[c] = 1'b0; end
        exp_w.delete();
        run_cmd("config", 8'd4, mask, 0, 0, 1, 1, 1'b0, '0, 0, '0);
    endtask

    task automatic do_unknown(input logic [7:0] c);
        exp_w.delete();
        run_cmd($sformatf("unknown%0h", c), c, 32'($urandom), 0, 0, 0, 1, 1'b0, '0, 0, '0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "/param_write"}, 64'(bus.param_write), 64'd0);
        check({tag, "/param_data"}, 64'(bus.param_data), 64'd0);
        check({tag, "/cmd_done"}, 64'(bus.cmd_done), 64'd0);
        check({tag, "/arg_advance"}, 64'(bus.arg_advance), 64'd0);
        check({tag, "/time_out_en"}, 64'(time_out_en), 64'd0);
        check({tag, "/time_out"}, time_out, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, nwr;
        rst = 1'b1; time_in = '0; latch_in = '0;
        bus.cmd = '0; bus.cmd_ready = 1'b0; bus.arg_data = '0;
        m_reset();
        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b0;
        repeat (S + 3) @(negedge clk);

        do_version();
        do_time(64'h0000_0001_8000_0000);

        latch_toggle(2'b01, 64'd900);
        latch_toggle(2'b01, 64'd1000);
        do_sync(0, 64'd5000, 64'd1200);
        do_latch(0);

        do_sync(1, rnd64(), rnd64());
        do_sync(7, rnd64(), rnd64());

        do_config(32'b10);
        latch_toggle(2'b10, 64'd3000);
        latch_toggle(2'b10, 64'd3100);
        latch_toggle(2'b10, 64'd3200);
        do_latch(1);
        do_latch(1);
        do_unknown(8'h5A);

        // Reset in the middle of GET_LATCH, with latch_in[0] high only while reset is held.
        latch_toggle(2'b01, 64'd7777);
        bus.cmd = 8'd3; bus.cmd_ready = 1'b1; bus.arg_data = 32'd0;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1; latch_in[0] = 1'b1;
        @(negedge clk);
        #1 check_outputs_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0; latch_in = '0;
        m_reset();
        ndone = 0; nwr = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus.cmd_done) ndone++;
            if (bus.param_write) nwr++;
        end
        check("post_reset/cmd_done", 64'(ndone), 64'd0);
        check("post_reset/param_write", 64'(nwr), 64'd0);
        @(negedge clk);
        do_latch(0);
        do_latch(1);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: latch_toggle(N'($urandom_range(1, 3)), rnd64());
                1: do_latch($urandom_range(0, 2));
                2: do_sync($urandom_range(0, 2), rnd64(), rnd64());
                3: do_config(32'($urandom));
                4: do_time(rnd64());
                default: if ($urandom_range(0, 1) == 0) do_version();
                         else do_unknown(8'($urandom_range(5, 255)));
            endcase
        end
        do_latch(0);
        do_latch(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
